bounce_generator: RTL and testbench

Stimulus source for the button-cleanup hardware test system. It drives the "raw" end of the interface, producing a synthetic bouncy button waveform on command: bounce on press, a stable pressed interval, bounce on release, then a quiet cooldown. Its `raw` output feeds the debounce/cleanup block under test, so cleanup behaviour can be exercised on-chip without a physical switch.

---
 rtl/bounce_gen_pkg.sv | 26 ++
 rtl/bounce_lfsr.sv | 42 ++++
 rtl/bounce_generator.sv | 222 ++++++++++++++++++++++
 tb/tb_bounce_generator.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_gen_pkg.sv
// bounce_gen_pkg
//   Shared definitions for the synthetic bouncy-button generator:
//   FSM state encoding, LFSR width/taps and the LFSR step function.
//   Used by bounce_generator (top) and bounce_lfsr.

package bounce_gen_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESS_BOUNCE   = 3'd1,
        PRESSED        = 3'd2,
        RELEASE_BOUNCE = 3'd3,
        COOLDOWN       = 3'd4
    } state_e;

    // Galois right-shift LFSR step: feedback taken from bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        logic [LFSR_W-1:0] shifted;
        shifted = cur >> 1;
        return cur[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// bounce_lfsr
//   Free-running 16-bit Galois LFSR that supplies pseudo-random bounce
//   segment lengths. It steps on every clock so the sequence seen by the
//   generator is fully determined by the time since reset.
//
// Ports:
//   clk5     in   system clock
//   reset    in   asynchronous active-low reset (loads the seed)
//   state_o  out  current LFSR state
//
// Parameters:
//   SEED  reset value; an all-zero seed would lock the LFSR, so it is
//         replaced by 16'h0001.

module bounce_lfsr
    import bounce_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk5,
    input  logic              reset,
    output logic [LFSR_W-1:0] state_o
);

    localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? 16'h0001 : SEED;

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED_SAFE;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/bounce_generator.sv
// bounce_generator
//   On a start request, plays one synthetic bouncy button event on `raw`:
//   press bounce, stable press, release bounce, then a quiet cooldown.
//   Drives the raw input of the debounce block under test.
//
// Ports:
//   clk5       in   system clock (rising edge)
//   reset      in   asynchronous active-low reset
//   start      in   request one event; ignored while busy
//   n_bounce   in   glitches per bounce phase (0..15), sampled on start
//   press_len  in   stable pressed cycles, sampled on start (0 acts as 1)
//   raw        out  synthetic button level, 1 = pressed
//   busy       out  event in progress
//   done       out  one-cycle pulse when the event finishes
//
// Parameters:
//   GAP_W  bounce segment counter width; segments last 1..2^GAP_W cycles
//   SEED   LFSR reset value (0 is mapped to 1)
//
// Build option:
//   BOUNCE_FIXED_GAP_EN  when defined, every bounce segment lasts
//                        2^(GAP_W-1) cycles and the LFSR is not built.
//
// State table:
//   IDLE           | raw low, waiting for start
//   PRESS_BOUNCE   | initial high segment, then n_bounce (low, high) glitches
//   PRESSED        | raw high for press_len cycles
//   RELEASE_BOUNCE | initial low segment, then n_bounce (high, low) glitches
//   COOLDOWN       | raw low for 2^GAP_W cycles, then done

module bounce_generator
    import bounce_gen_pkg::*;
#(
    parameter int unsigned        GAP_W = 4,
    parameter logic [LFSR_W-1:0]  SEED  = 16'hACE1
) (
    input  logic        clk5,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  n_bounce,
    input  logic [15:0] press_len,
    output logic        raw,
    output logic        busy,
    output logic        done
);

    state_e            state_q, state_d;
    logic              raw_q, raw_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [GAP_W-1:0]  seg_q, seg_d;
    logic [3:0]        glitch_q, glitch_d;
    logic [3:0]        nb_q, nb_d;
    logic [15:0]       plen_q, plen_d;
    logic [15:0]       pcnt_q, pcnt_d;

    // Value loaded into the segment counter at each segment start (gap-1).
    logic [GAP_W-1:0]  gap_m1;
    logic [15:0]       plen_in;

`ifdef BOUNCE_FIXED_GAP_EN
    localparam logic [GAP_W-1:0] FIXED_GAP_M1 = GAP_W'((1 << (GAP_W - 1)) - 1);

    logic unused_seed;
    assign unused_seed = ^SEED;
    assign gap_m1      = FIXED_GAP_M1;
`else
    logic [LFSR_W-1:0] lfsr_state;
    logic              unused_lfsr_hi;

    bounce_lfsr #(
        .SEED    (SEED)
    ) u_lfsr (
        .clk5    (clk5),
        .reset   (reset),
        .state_o (lfsr_state)
    );

    assign gap_m1         = lfsr_state[GAP_W-1:0];
    assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:GAP_W];
`endif

    assign plen_in = (press_len == 16'd0) ? 16'd1 : press_len;

    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            raw_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            seg_q    <= '0;
            glitch_q <= '0;
            nb_q     <= '0;
            plen_q   <= '0;
            pcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            raw_q    <= raw_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            seg_q    <= seg_d;
            glitch_q <= glitch_d;
            nb_q     <= nb_d;
            plen_q   <= plen_d;
            pcnt_q   <= pcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        raw_d    = raw_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        seg_d    = seg_q;
        glitch_d = glitch_q;
        nb_d     = nb_q;
        plen_d   = plen_q;
        pcnt_d   = pcnt_q;

        unique case (state_q)
            IDLE: begin
                raw_d  = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    nb_d   = n_bounce;
                    plen_d = plen_in;
                    busy_d = 1'b1;
                    raw_d  = 1'b1;
                    if (n_bounce != 4'd0) begin
                        state_d  = PRESS_BOUNCE;
                        seg_d    = gap_m1;
                        glitch_d = n_bounce;
                    end else begin
                        // No bounce: the first high cycle already counts as pressed.
                        state_d = PRESSED;
                        pcnt_d  = plen_in - 16'd1;
                    end
                end
            end

            PRESS_BOUNCE: begin
                if (seg_q == '0) begin
                    if (raw_q) begin
                        if (glitch_q == 4'd0) begin
                            state_d = PRESSED;
                            pcnt_d  = plen_q - 16'd1;
                        end else begin
                            raw_d = 1'b0;
                            seg_d = gap_m1;
                        end
                    end else begin
                        // A glitch completes when raw returns high.
                        raw_d    = 1'b1;
                        glitch_d = glitch_q - 4'd1;
                        seg_d    = gap_m1;
                    end
                end else begin
                    seg_d = seg_q - 1'b1;
                end
            end

            PRESSED: begin
                if (pcnt_q == 16'd0) begin
                    raw_d = 1'b0;
                    if (nb_q == 4'd0) begin
                        state_d = COOLDOWN;
                        seg_d   = '1;
                    end else begin
                        state_d  = RELEASE_BOUNCE;
                        seg_d    = gap_m1;
                        glitch_d = nb_q;
                    end
                end else begin
                    pcnt_d = pcnt_q - 16'd1;
                end
            end

            RELEASE_BOUNCE: begin
                if (seg_q == '0) begin
                    if (!raw_q) begin
                        if (glitch_q == 4'd0) begin
                            state_d = COOLDOWN;
                            seg_d   = '1;
                        end else begin
                            raw_d = 1'b1;
                            seg_d = gap_m1;
                        end
                    end else begin
                        // A glitch completes when raw returns low.
                        raw_d    = 1'b0;
                        glitch_d = glitch_q - 4'd1;
                        seg_d    = gap_m1;
                    end
                end else begin
                    seg_d = seg_q - 1'b1;
                end
            end

            COOLDOWN: begin
                // Counter loaded with all ones, so this lasts 2^GAP_W cycles.
                if (seg_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    seg_d = seg_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                raw_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign raw  = raw_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_bounce_generator.sv
// tb_bounce_generator
//   Self-checking bench for bounce_generator. The reference model turns each
//   accepted start into the full expected waveform (segment list expanded
//   into a per-cycle queue of {raw, busy, done}) and every cycle's outputs
//   are compared against it.

module tb_bounce_generator;

    localparam int          GAP_W = 4;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          COOL  = 1 << GAP_W;

    logic        clk5 = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  n_bounce;
    logic [15:0] press_len;
    logic        raw;
    logic        busy;
    logic        done;

    int          n_vec = 0;
    int          n_err = 0;
    int          done_seen = 0;

    logic [2:0]  cur;          // expected {raw, busy, done} for the current cycle
    logic [2:0]  exp_q[$];     // expected values for following cycles
    logic [15:0] m_lfsr;       // LFSR value during the current cycle

    bounce_generator #(
        .GAP_W     (GAP_W),
        .SEED      (SEED)
    ) dut (
        .clk5      (clk5),
        .reset     (reset),
        .start     (start),
        .n_bounce  (n_bounce),
        .press_len (press_len),
        .raw       (raw),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk5 = ~clk5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, expv);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Length of a bounce segment whose counter is loaded in cycle t of the
    // event (cycle 0 = the cycle start is sampled in).
    function automatic int gap_at(input logic [15:0] l0, input int t);
        logic [15:0] v;
        v = l0;
        for (int i = 0; i < t; i++) v = lfsr_step(v);
`ifdef BOUNCE_FIXED_GAP_EN
        return 1 << (GAP_W - 1);
`else
        return 1 + (int'(v) % (1 << GAP_W));
`endif
    endfunction

    task automatic push_seg(input logic lvl, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back({lvl, 1'b1, 1'b0});
    endtask

    task automatic build_event(input logic [15:0] l0, input int nb, input int pl);
        int t;
        int g;
        int plv;
        plv = (pl == 0) ? 1 : pl;
        t = 0;
        if (nb != 0) begin
            g = gap_at(l0, t); push_seg(1'b1, g); t += g;
            for (int i = 0; i < nb; i++) begin
                g = gap_at(l0, t); push_seg(1'b0, g); t += g;
                g = gap_at(l0, t); push_seg(1'b1, g); t += g;
            end
        end
        push_seg(1'b1, plv); t += plv;
        if (nb != 0) begin
            g = gap_at(l0, t); push_seg(1'b0, g); t += g;
            for (int i = 0; i < nb; i++) begin
                g = gap_at(l0, t); push_seg(1'b1, g); t += g;
                g = gap_at(l0, t); push_seg(1'b0, g); t += g;
            end
        end
        push_seg(1'b0, COOL);
        exp_q.push_back(3'b001);
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, check
    // outputs at the following falling edge.
    task automatic cycle(input logic st, input logic [3:0] nb, input logic [15:0] pl);
        start     = st;
        n_bounce  = nb;
        press_len = pl;
        @(posedge clk5);
        if (st && !cur[1]) begin
            exp_q.delete();
            build_event(m_lfsr, int'(nb), int'(pl));
        end
        cur    = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
        m_lfsr = lfsr_step(m_lfsr);
        @(negedge clk5);
        chk("raw",  32'(raw),  32'(cur[2]));
        chk("busy", 32'(busy), 32'(cur[1]));
        chk("done", 32'(done), 32'(cur[0]));
        if (done === 1'b1) done_seen++;
        start = 1'b0;
    endtask

    task automatic run_to_idle(input int max);
        int i;
        i = 0;
        while ((cur != 3'b000 || exp_q.size() != 0) && i < max) begin
            cycle(1'b0, 4'd0, 16'd0);
            i++;
        end
        if (i >= max) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Called just after a falling edge; asserts reset mid-cycle.
    task automatic async_reset(input int hold);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_raw",  32'(raw),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        exp_q.delete();
        cur    = 3'b000;
        m_lfsr = SEED;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk5);
            chk("rst_hold_raw",  32'(raw),  32'd0);
            chk("rst_hold_busy", 32'(busy), 32'd0);
            chk("rst_hold_done", 32'(done), 32'd0);
        end
        #2;
        reset = 1'b1;
    endtask

    initial begin
        logic hit;

        // Reset held with start asserted.
        reset     = 1'b0;
        start     = 1'b1;
        n_bounce  = 4'd3;
        press_len = 16'd7;
        cur       = 3'b000;
        m_lfsr    = SEED;
        #1;
        chk("por_raw",  32'(raw),  32'd0);
        chk("por_busy", 32'(busy), 32'd0);
        chk("por_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk5);
            chk("por_hold_raw",  32'(raw),  32'd0);
            chk("por_hold_busy", 32'(busy), 32'd0);
            chk("por_hold_done", 32'(done), 32'd0);
        end
        start = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'd0, 16'd0);

        // No bounce.
        done_seen = 0;
        cycle(1'b1, 4'd0, 16'd5);
        run_to_idle(200);
        chk("nobounce_done_cnt", 32'(done_seen), 32'd1);

        // Bounce, with a second start while busy.
        done_seen = 0;
        cycle(1'b1, 4'd2, 16'd20);
        for (int i = 0; i < 9; i++) cycle(1'b0, 4'd0, 16'd0);
        cycle(1'b1, 4'd5, 16'd3);
        run_to_idle(1000);
        chk("busy_rej_done_cnt", 32'(done_seen), 32'd1);

        // press_len of zero acts as one.
        cycle(1'b1, 4'd1, 16'd0);
        run_to_idle(500);
        cycle(1'b1, 4'd0, 16'd0);
        run_to_idle(500);

        // Mid-event reset, then a full event.
        done_seen = 0;
        cycle(1'b1, 4'd3, 16'd10);
        for (int i = 0; i < 11; i++) cycle(1'b0, 4'd0, 16'd0);
        async_reset(2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 16'd0);
        chk("midrst_no_done", 32'(done_seen), 32'd0);
        cycle(1'b1, 4'd1, 16'd4);
        run_to_idle(500);
        chk("after_rst_done_cnt", 32'(done_seen), 32'd1);

        // Start in the same cycle as done.
        hit = 1'b0;
        cycle(1'b1, 4'd1, 16'd2);
        for (int i = 0; i < 500 && !hit; i++) begin
            if (cur[0]) begin
                cycle(1'b1, 4'd2, 16'd3);
                hit = 1'b1;
            end else begin
                cycle(1'b0, 4'd0, 16'd0);
            end
        end
        chk("start_on_done_seen", 32'(hit), 32'd1);
        run_to_idle(1000);

        // Maximum bounce count, repeated after a reset.
        cycle(1'b1, 4'd15, 16'd6);
        run_to_idle(2000);
        async_reset(1);
        cycle(1'b1, 4'd15, 16'd6);
        run_to_idle(2000);

        // Random starts, including many while busy.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 9) == 0),
                  4'($urandom_range(0, 15)),
                  16'($urandom_range(0, 40)));
        end
        run_to_idle(2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
